gpr_fwd_scoreboard: RTL and testbench

//  Parametrised GPR operand-forwarding unit with long-latency scoreboard, sitting at the ID stage.

---
 rtl/gpr_fwd_scoreboard_pkg.sv | 16 +
 rtl/gpr_fwd_scoreboard_if.sv | 48 ++++
 rtl/gpr_fwd_scoreboard_port.sv | 53 +++++
 rtl/gpr_fwd_scoreboard.sv | 95 +++++++++
 tb/tb_gpr_fwd_scoreboard.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_fwd_scoreboard_pkg.sv
// Shared defaults and constants for the GPR forwarding unit.
package gpr_fwd_scoreboard_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int NUM_RD_DEF  = 2;
    localparam int NUM_FWD_DEF = 3;
    localparam int MAX_OUT_DEF = 4;
    localparam int ZERO_REG    = 0;
    localparam int STALL_W     = 32;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gpr_fwd_scoreboard_if.sv
// ID-stage operand/forwarding/long-latency bus; slave = the unit, master = driver.
interface gpr_fwd_scoreboard_if
    import gpr_fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = NUM_RD_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) ();

    logic [NUM_RD-1:0]         i_rd_en;
    logic [NUM_RD*ADDR_W-1:0]  i_raddr;
    logic [NUM_RD*DATA_W-1:0]  i_rdata;
    logic [NUM_FWD-1:0]        i_fwd_wen;
    logic [NUM_FWD-1:0]        i_fwd_ready;
    logic [NUM_FWD*ADDR_W-1:0] i_fwd_waddr;
    logic [NUM_FWD*DATA_W-1:0] i_fwd_wdata;
    logic                      i_ll_issue;
    logic [ADDR_W-1:0]         i_ll_waddr;
    logic                      i_ll_done;
    logic [ADDR_W-1:0]         i_ll_done_addr;
    logic [DATA_W-1:0]         i_ll_done_data;
    logic [NUM_RD*DATA_W-1:0]  o_rdata;
    logic                      o_stall;
    logic                      o_ll_ready;
    logic                      o_ll_full;
    logic                      o_err;
    logic [STALL_W-1:0]        o_stall_cnt;

    modport slave (
        input  i_rd_en, i_raddr, i_rdata,
        input  i_fwd_wen, i_fwd_ready, i_fwd_waddr, i_fwd_wdata,
        input  i_ll_issue, i_ll_waddr,
        input  i_ll_done, i_ll_done_addr, i_ll_done_data,
        output o_rdata, o_stall, o_ll_ready, o_ll_full,
        output o_err, o_stall_cnt
    );

    modport master (
        output i_rd_en, i_raddr, i_rdata,
        output i_fwd_wen, i_fwd_ready, i_fwd_waddr, i_fwd_wdata,
        output i_ll_issue, i_ll_waddr,
        output i_ll_done, i_ll_done_addr, i_ll_done_data,
        input  o_rdata, o_stall, o_ll_ready, o_ll_full,
        input  o_err, o_stall_cnt
    );

endinterface

// File: rtl/gpr_fwd_scoreboard_port.sv
// One read port: priority select over in-pipe sources, completion bus, scoreboard.
module gpr_fwd_scoreboard_port
    import gpr_fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic                      en_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         rdata_i,
    input  logic [NUM_FWD-1:0]        fwd_wen_i,
    input  logic [NUM_FWD-1:0]        fwd_ready_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic                      ll_done_i,
    input  logic [ADDR_W-1:0]         ll_done_addr_i,
    input  logic [DATA_W-1:0]         ll_done_data_i,
    input  logic                      pending_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      hazard_o
);

    logic hit;

    // The youngest matching source decides; an unready one never falls through.
    always_comb begin
        data_o   = rdata_i;
        hazard_o = 1'b0;
        hit      = 1'b0;
        if (addr_i == ADDR_W'(ZERO_REG)) begin
            data_o = '0;
        end else if (en_i) begin
            for (int s = 0; s < NUM_FWD; s++) begin
                if (!hit && fwd_wen_i[s] &&
                    fwd_waddr_i[s*ADDR_W +: ADDR_W] == addr_i) begin
                    hit = 1'b1;
                    if (fwd_ready_i[s])
                        data_o = fwd_wdata_i[s*DATA_W +: DATA_W];
                    else
                        hazard_o = 1'b1;
                end
            end
            if (!hit) begin
                if (ll_done_i && ll_done_addr_i == addr_i)
                    data_o = ll_done_data_i;
                else if (pending_i)
                    hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_fwd_scoreboard.sv
// ID-stage operand forwarding with a long-latency write scoreboard.
module gpr_fwd_scoreboard
    import gpr_fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = NUM_RD_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input logic                i_clk,
    input logic                i_rst_n,
    gpr_fwd_scoreboard_if.slave bus
);

    localparam int CW   = cnt_w(MAX_OUT);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0]          pending_q, pending_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [STALL_W-1:0]       scnt_q, scnt_d;
    logic [NUM_RD*DATA_W-1:0] rdata_w;
    logic [NUM_RD-1:0]        haz_w;
    logic                     stall, full, blocked, ready;
    logic                     accept, done_hit, done_same;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_port
        gpr_fwd_scoreboard_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_FWD(NUM_FWD)
        ) u_port (
            .en_i          (bus.i_rd_en[r]),
            .addr_i        (bus.i_raddr[r*ADDR_W +: ADDR_W]),
            .rdata_i       (bus.i_rdata[r*DATA_W +: DATA_W]),
            .fwd_wen_i     (bus.i_fwd_wen),
            .fwd_ready_i   (bus.i_fwd_ready),
            .fwd_waddr_i   (bus.i_fwd_waddr),
            .fwd_wdata_i   (bus.i_fwd_wdata),
            .ll_done_i     (bus.i_ll_done),
            .ll_done_addr_i(bus.i_ll_done_addr),
            .ll_done_data_i(bus.i_ll_done_data),
            .pending_i     (pending_q[bus.i_raddr[r*ADDR_W +: ADDR_W]]),
            .data_o        (rdata_w[r*DATA_W +: DATA_W]),
            .hazard_o      (haz_w[r])
        );
    end

    assign stall     = |haz_w;
    assign full      = (cnt_q == CW'(MAX_OUT));
    assign done_same = bus.i_ll_done &&
                       (bus.i_ll_done_addr == bus.i_ll_waddr);
    // A completion to the same register frees the WAW slot this cycle.
    assign blocked   = pending_q[bus.i_ll_waddr] && !done_same;
    assign ready     = !full && !blocked;
    assign accept    = bus.i_ll_issue && ready &&
                       (bus.i_ll_waddr != ADDR_W'(ZERO_REG));
    assign done_hit  = bus.i_ll_done && pending_q[bus.i_ll_done_addr];

    always_comb begin
        pending_d = pending_q;
        if (bus.i_ll_done)
            pending_d[bus.i_ll_done_addr] = 1'b0;
        if (accept)
            pending_d[bus.i_ll_waddr] = 1'b1;
        cnt_d  = cnt_q + CW'(accept) - CW'(done_hit);
        err_d  = err_q | (bus.i_ll_done && !done_hit);
        scnt_d = scnt_q;
        if (stall && scnt_q != '1)
            scnt_d = scnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            scnt_q    <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            scnt_q    <= scnt_d;
        end
    end

    assign bus.o_rdata     = rdata_w;
    assign bus.o_stall     = stall;
    assign bus.o_ll_ready  = ready;
    assign bus.o_ll_full   = full;
    assign bus.o_err       = err_q;
    assign bus.o_stall_cnt = scnt_q;

endmodule

// File: tb/tb_gpr_fwd_scoreboard.sv
// Directed and random bench for gpr_fwd_scoreboard against a set-based model.
module tb_gpr_fwd_scoreboard;
    import gpr_fwd_scoreboard_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NF = 3;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpr_fwd_scoreboard_if #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_FWD(NF)
    ) bus ();

    gpr_fwd_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
        .NUM_FWD(NF), .MAX_OUT(MO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    bit          m_pend[32];
    bit          m_err;
    logic [31:0] m_scnt;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pend_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_err  = 1'b0;
        m_scnt = '0;
    endtask

    task automatic clr();
        bus.i_rd_en        = '0;
        bus.i_raddr        = '0;
        bus.i_rdata        = '0;
        bus.i_fwd_wen      = '0;
        bus.i_fwd_ready    = '0;
        bus.i_fwd_waddr    = '0;
        bus.i_fwd_wdata    = '0;
        bus.i_ll_issue     = 1'b0;
        bus.i_ll_waddr     = '0;
        bus.i_ll_done      = 1'b0;
        bus.i_ll_done_addr = '0;
        bus.i_ll_done_data = '0;
    endtask

    task automatic rd(input int r, input int a, input logic [31:0] d);
        bus.i_rd_en[r]          = 1'b1;
        bus.i_raddr[r*AW +: AW] = AW'(a);
        bus.i_rdata[r*DW +: DW] = d;
    endtask

    task automatic src(input int s, input int a, input bit rdy,
                       input logic [31:0] d);
        bus.i_fwd_wen[s]            = 1'b1;
        bus.i_fwd_ready[s]          = rdy;
        bus.i_fwd_waddr[s*AW +: AW] = AW'(a);
        bus.i_fwd_wdata[s*DW +: DW] = d;
    endtask

    // Reference view of one read port, straight from the resolution rules.
    task automatic model_port(input int r, output logic [31:0] d,
                              output bit h);
        int a;
        a = int'(bus.i_raddr[r*AW +: AW]);
        d = bus.i_rdata[r*DW +: DW];
        h = 1'b0;
        if (a == 0) begin
            d = '0;
            return;
        end
        if (!bus.i_rd_en[r]) return;
        for (int s = 0; s < NF; s++) begin
            if (bus.i_fwd_wen[s] &&
                int'(bus.i_fwd_waddr[s*AW +: AW]) == a) begin
                if (bus.i_fwd_ready[s]) d = bus.i_fwd_wdata[s*DW +: DW];
                else h = 1'b1;
                return;
            end
        end
        if (bus.i_ll_done && int'(bus.i_ll_done_addr) == a) begin
            d = bus.i_ll_done_data;
            return;
        end
        h = m_pend[a];
    endtask

    // Check everything visible this cycle, then advance the model one edge.
    task automatic step();
        logic [31:0] d[NR];
        bit          h[NR];
        bit          stl, rdy, acc;
        int          wa, da;
        #1;
        stl = 1'b0;
        for (int r = 0; r < NR; r++) begin
            model_port(r, d[r], h[r]);
            stl |= h[r];
        end
        wa  = int'(bus.i_ll_waddr);
        da  = int'(bus.i_ll_done_addr);
        rdy = (pend_count() != MO) &&
              !(m_pend[wa] && !(bus.i_ll_done && da == wa));
        acc = bus.i_ll_issue && rdy && wa != 0;
        if (!stl)
            for (int r = 0; r < NR; r++)
                chk("rdata", bus.o_rdata[r*DW +: DW], d[r]);
        chk("stall", 32'(bus.o_stall), 32'(stl));
        chk("ll_ready", 32'(bus.o_ll_ready), 32'(rdy));
        chk("ll_full", 32'(bus.o_ll_full), 32'(pend_count() == MO));
        chk("err", 32'(bus.o_err), 32'(m_err));
        chk("stall_cnt", bus.o_stall_cnt, m_scnt);
        if (bus.i_ll_done) begin
            if (m_pend[da]) m_pend[da] = 1'b0;
            else m_err = 1'b1;
        end
        if (acc) m_pend[wa] = 1'b1;
        if (stl && m_scnt != 32'hFFFF_FFFF) m_scnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int a);
        clr();
        bus.i_ll_issue = 1'b1;
        bus.i_ll_waddr = AW'(a);
        step();
    endtask

    task automatic done(input int a, input logic [31:0] d);
        clr();
        bus.i_ll_done      = 1'b1;
        bus.i_ll_done_addr = AW'(a);
        bus.i_ll_done_data = d;
        step();
    endtask

    initial begin
        clr();
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(bus.o_stall), 32'd0);
        chk("rst_ready", 32'(bus.o_ll_ready), 32'd1);
        chk("rst_full", 32'(bus.o_ll_full), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_scnt", bus.o_stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Youngest ready source wins
        clr();
        src(0, 5, 1'b1, 32'hAAAA);
        src(1, 5, 1'b1, 32'hBBBB);
        rd(0, 5, 32'h1111);
        rd(1, 0, 32'h0);
        #1;
        chk("exe_fwd", bus.o_rdata[DW-1:0], 32'hAAAA);
        chk("exe_fwd_stall", 32'(bus.o_stall), 32'd0);
        step();

        // Unready EXE blocks the ready MEM copy
        clr();
        src(0, 7, 1'b0, 32'h0);
        src(1, 7, 1'b1, 32'h1234);
        rd(0, 7, 32'h2222);
        #1;
        chk("no_fallthru", 32'(bus.o_stall), 32'd1);
        step();

        // Long-latency RAW: stall until completion, then bypass
        issue(9);
        clr();
        rd(0, 9, 32'h3333);
        #1;
        chk("ll_raw", 32'(bus.o_stall), 32'd1);
        step();
        clr();
        rd(1, 9, 32'h3333);
        step();
        clr();
        rd(0, 9, 32'h3333);
        bus.i_ll_done      = 1'b1;
        bus.i_ll_done_addr = AW'(9);
        bus.i_ll_done_data = 32'h55;
        #1;
        chk("ll_bypass", bus.o_rdata[DW-1:0], 32'h55);
        chk("ll_bypass_stall", 32'(bus.o_stall), 32'd0);
        step();

        // Capacity limit
        for (int i = 1; i <= MO; i++) issue(i);
        clr();
        bus.i_ll_issue = 1'b1;
        bus.i_ll_waddr = AW'(6);
        #1;
        chk("full", 32'(bus.o_ll_full), 32'd1);
        chk("full_ready", 32'(bus.o_ll_ready), 32'd0);
        bus.i_ll_done      = 1'b1;
        bus.i_ll_done_addr = AW'(1);
        step();

        // WAW gating and same-cycle release
        clr();
        bus.i_ll_issue = 1'b1;
        bus.i_ll_waddr = AW'(3);
        #1;
        chk("waw_block", 32'(bus.o_ll_ready), 32'd0);
        bus.i_ll_done      = 1'b1;
        bus.i_ll_done_addr = AW'(3);
        #1;
        chk("waw_release", 32'(bus.o_ll_ready), 32'd1);
        step();
        clr();
        rd(0, 3, 32'h0);
        #1;
        chk("waw_still_pend", 32'(bus.o_stall), 32'd1);
        step();
        done(2, 32'h0);
        done(3, 32'h0);
        done(4, 32'h0);

        // Orphan completion
        done(12, 32'h0);
        #1;
        chk("orphan_err", 32'(bus.o_err), 32'd1);

        // Asynchronous reset mid-cycle
        issue(10);
        issue(11);
        clr();
        rd(0, 10, 32'h4444);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_err", 32'(bus.o_err), 32'd0);
        chk("arst_stall", 32'(bus.o_stall), 32'd0);
        chk("arst_scnt", bus.o_stall_cnt, 32'd0);
        chk("arst_data", bus.o_rdata[DW-1:0], 32'h4444);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done(10, 32'h0);
        #1;
        chk("late_done_err", 32'(bus.o_err), 32'd1);

        // Random traffic over a small register window
        for (int n = 0; n < 400; n++) begin
            clr();
            for (int r = 0; r < NR; r++) begin
                int a;
                a = $urandom_range(0, 7);
                bus.i_rd_en[r]          = $urandom_range(0, 3) != 0;
                bus.i_raddr[r*AW +: AW] = AW'(a);
                bus.i_rdata[r*DW +: DW] = (a == 0) ? 32'h0 : $urandom;
            end
            for (int s = 0; s < NF; s++) begin
                bus.i_fwd_wen[s]            = $urandom_range(0, 2) == 0;
                bus.i_fwd_ready[s]          = $urandom_range(0, 3) != 0;
                bus.i_fwd_waddr[s*AW +: AW] = AW'($urandom_range(0, 7));
                bus.i_fwd_wdata[s*DW +: DW] = $urandom;
            end
            bus.i_ll_issue     = $urandom_range(0, 2) == 0;
            bus.i_ll_waddr     = AW'($urandom_range(0, 7));
            bus.i_ll_done      = $urandom_range(0, 2) == 0;
            bus.i_ll_done_addr = AW'($urandom_range(1, 7));
            bus.i_ll_done_data = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
